// File: rtl/wifi_payload_builder_if.sv
// Byte/record handshake bundle between the payload builder and its neighbours.
// master = feeder + wifi_rtl side, slave = wifi_payload_builder.
interface wifi_payload_builder_if #(
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [CNT_W-1:0] wr_count;
  logic             wr_full;
  logic             overflow;
  logic [6:0]       rec_level;
  logic             start;
  logic             busy;
  logic             done;
  logic [7:0]       data_out;
  logic             data_out_valid;
  logic             data_accepted;
  logic             data_end;
  logic             send_post;

  modport master (
    output wr_en, wr_count, start, data_accepted,
    input  wr_full, overflow, rec_level, busy, done,
    input  data_out, data_out_valid, data_end, send_post
  );

  modport slave (
    input  wr_en, wr_count, start, data_accepted,
    output wr_full, overflow, rec_level, busy, done,
    output data_out, data_out_valid, data_end, send_post
  );
endinterface

// File: rtl/wifi_payload_builder.sv
// Record FIFO + ASCII "II:CCC," serialiser feeding wifi_rtl (txclk domain).
// Define WIFI_PAYLOAD_CRLF_EN to terminate the payload with CR LF.
module wifi_payload_builder #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                  txclk,
  input  logic                  reset_n,
  wifi_payload_builder_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef WIFI_PAYLOAD_CRLF_EN
  localparam logic [2:0] LAST_B = 3'd7;
`else
  localparam logic [2:0] LAST_B = 3'd5;
`endif

  typedef enum logic [2:0] {
    IDLE, LOAD, EMIT, ENDP, POST, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [6:0] level_q, level_d;
  logic [6:0] batch_n_q, batch_n_d;
  logic [6:0] rec_idx_q, rec_idx_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic       ovf_q, ovf_d;
  logic [4:0][7:0] dig_q, dig_d;

  logic       full, push, pop, start_ok;
  logic       is_last, fire, byte_done;
  logic [2:0] end_b;
  logic [7:0] cur_b;
  logic [31:0] cnt_w, idx_w;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (level_q == 7'(DEPTH));
  assign push     = bus.wr_en && !full;
  assign pop      = (state_q == LOAD);
  assign start_ok = bus.start && (state_q == IDLE);
  assign is_last  = (rec_idx_q + 7'd1) >= batch_n_q;
  assign end_b    = is_last ? LAST_B : 3'd6;
  assign fire     = (state_q == EMIT) && bus.data_accepted;
  assign byte_done = fire && (byte_idx_q == end_b);

  assign bus.wr_full   = full;
  assign bus.overflow  = ovf_q;
  assign bus.rec_level = level_q;

  always_ff @(posedge txclk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_count;
  end

  always_ff @(posedge txclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      batch_n_q  <= '0;
      rec_idx_q  <= '0;
      byte_idx_q <= '0;
      ovf_q      <= 1'b0;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      batch_n_q  <= batch_n_d;
      rec_idx_q  <= rec_idx_d;
      byte_idx_q <= byte_idx_d;
      ovf_q      <= ovf_d;
      dig_q      <= dig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start)
              state_d = (level_q == '0) ? DONE : LOAD;
      LOAD: state_d = EMIT;
      EMIT: if (byte_done)
              state_d = is_last ? ENDP : LOAD;
      ENDP: state_d = POST;
      POST: if (bus.data_accepted) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Digits come from the registered head entry and index, clamped to 3 digits.
  always_comb begin
    cnt_w = 32'(mem_q[rd_ptr_q]);
    if (cnt_w > 32'd999) cnt_w = 32'd999;
    idx_w = 32'(rec_idx_q);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    batch_n_d  = batch_n_q;
    rec_idx_d  = rec_idx_q;
    byte_idx_d = byte_idx_q;
    ovf_d      = ovf_q;
    dig_d      = dig_q;
    if (push) wr_ptr_d = nxt(wr_ptr_q);
    if (pop)  rd_ptr_d = nxt(rd_ptr_q);
    level_d = level_q + 7'(push) - 7'(pop);
    if (start_ok) begin
      ovf_d     = 1'b0;
      batch_n_d = level_q;
      rec_idx_d = '0;
    end
    if (bus.wr_en && full) ovf_d = 1'b1;
    if (pop) begin
      byte_idx_d = '0;
      dig_d[0] = 8'(32'h30 + idx_w / 32'd10);
      dig_d[1] = 8'(32'h30 + idx_w % 32'd10);
      dig_d[2] = 8'(32'h30 + cnt_w / 32'd100);
      dig_d[3] = 8'(32'h30 + (cnt_w / 32'd10) % 32'd10);
      dig_d[4] = 8'(32'h30 + cnt_w % 32'd10);
    end else if (fire) begin
      byte_idx_d = byte_idx_q + 3'd1;
    end
    if (byte_done && !is_last) rec_idx_d = rec_idx_q + 7'd1;
  end

  always_comb begin
    cur_b = 8'h00;
    unique case (byte_idx_q)
      3'd0: cur_b = dig_q[0];
      3'd1: cur_b = dig_q[1];
      3'd2: cur_b = 8'h3A;
      3'd3: cur_b = dig_q[2];
      3'd4: cur_b = dig_q[3];
      3'd5: cur_b = dig_q[4];
`ifdef WIFI_PAYLOAD_CRLF_EN
      3'd6: cur_b = is_last ? 8'h0D : 8'h2C;
`else
      3'd6: cur_b = 8'h2C;
`endif
      3'd7: cur_b = 8'h0A;
    endcase
  end

  always_comb begin
    bus.busy           = (state_q != IDLE);
    bus.done           = 1'b0;
    bus.data_out       = 8'h00;
    bus.data_out_valid = 1'b0;
    bus.data_end       = 1'b0;
    bus.send_post      = 1'b0;
    unique case (1'b1)
      (state_q == EMIT): begin
        bus.data_out_valid = 1'b1;
        bus.data_out       = cur_b;
      end
      (state_q == ENDP): bus.data_end = 1'b1;
      (state_q == POST): begin
        bus.data_out_valid = 1'b1;
        bus.send_post      = 1'b1;
      end
      (state_q == DONE): bus.done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wifi_payload_builder.sv
// Scoreboard bench for wifi_payload_builder (DEPTH=16, CNT_W=10).
// Expected bytes are queued at start and popped on each accepted byte.
module tb_wifi_payload_builder;
  localparam int DEPTH = 16;
  localparam int CNT_W = 10;

  logic txclk = 1'b0;
  logic reset_n;

  wifi_payload_builder_if #(.CNT_W(CNT_W)) bus();

  wifi_payload_builder #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .txclk  (txclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 txclk = ~txclk;

  int errors = 0;
  int checks = 0;
  int n_end = 0;
  int n_post = 0;
  int n_valid = 0;
  int n_bytes = 0;
  logic [7:0] exp_q[$];
  int mdl[$];

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic monitor();
    logic hold;
    logic [7:0] hold_b;
    logic [7:0] e;
    hold = 1'b0;
    hold_b = '0;
    forever begin
      @(negedge txclk);
      if (!reset_n) begin
        hold = 1'b0;
        continue;
      end
      if (bus.data_end) n_end++;
      if (bus.data_out_valid) n_valid++;
      if (bus.data_out_valid && bus.send_post) begin
        checks++;
        if (bus.data_out !== 8'h00) begin
          errors++;
          $display("FAIL post_data got=%h exp=00", bus.data_out);
        end
        if (bus.data_accepted) n_post++;
      end
      if (bus.data_out_valid && !bus.send_post) begin
        if (hold) begin
          checks++;
          if (bus.data_out !== hold_b) begin
            errors++;
            $display("FAIL hold_stable got=%h exp=%h", bus.data_out, hold_b);
          end
        end
        if (bus.data_accepted) begin
          checks++;
          n_bytes++;
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_byte got=%h exp=none", bus.data_out);
          end else begin
            e = exp_q.pop_front();
            if (bus.data_out !== e) begin
              errors++;
              $display("FAIL byte got=%h exp=%h", bus.data_out, e);
            end
          end
        end else begin
          hold = 1'b1;
          hold_b = bus.data_out;
        end
      end else begin
        hold = 1'b0;
      end
    end
  endtask

  task automatic do_write(input int cnt);
    bus.wr_en = 1'b1;
    bus.wr_count = CNT_W'(cnt);
    if (mdl.size() < DEPTH) mdl.push_back(cnt);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic load_expect();
    int n;
    int c;
    n = mdl.size();
    for (int i = 0; i < n; i++) begin
      c = (mdl[i] > 999) ? 999 : mdl[i];
      exp_q.push_back(8'(32'h30 + i / 10));
      exp_q.push_back(8'(32'h30 + i % 10));
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'(32'h30 + c / 100));
      exp_q.push_back(8'(32'h30 + (c / 10) % 10));
      exp_q.push_back(8'(32'h30 + c % 10));
      if (i != n - 1) exp_q.push_back(8'h2C);
`ifdef WIFI_PAYLOAD_CRLF_EN
      if (i == n - 1) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
`endif
    end
    mdl.delete();
  endtask

  task automatic do_start();
    load_expect();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int div, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge txclk);
      #1;
      bus.data_accepted = (div <= 1) ? 1'b1 : ((c % div) == 0);
      @(negedge txclk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    bus.data_accepted = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.data_out_valid, bus.data_end,
         bus.send_post, bus.wr_full, bus.overflow} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000000",
        {bus.busy, bus.done, bus.data_out_valid, bus.data_end,
         bus.send_post, bus.wr_full, bus.overflow});
    end
    checks++;
    if (bus.rec_level !== 7'd0 || bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_level got=%0d/%h exp=0/00", bus.rec_level, bus.data_out);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_basic(input int div);
    bit ok;
    int e0, p0;
    e0 = n_end;
    p0 = n_post;
    do_write(5);
    do_write(123);
    checks++;
    if (bus.rec_level !== 7'd2) begin
      errors++;
      $display("FAIL basic_level got=%0d exp=2", bus.rec_level);
    end
    do_start();
    checks++;
    if (bus.data_out_valid !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL latency_load got=%b%b exp=01", bus.data_out_valid, bus.busy);
    end
    if (div > 1) begin
      bus.start = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'h30) begin
      errors++;
      $display("FAIL latency_emit got=%b/%h exp=1/30", bus.data_out_valid, bus.data_out);
    end
    wait_done(200, div, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_timeout got=nodone exp=done");
    end
    checks++;
    if (n_end - e0 != 1 || n_post - p0 != 1) begin
      errors++;
      $display("FAIL basic_end_post got=%0d/%0d exp=1/1", n_end - e0, n_post - p0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_left got=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rec_level !== 7'd0) begin
      errors++;
      $display("FAIL basic_idle got=%b%b/%0d exp=00/0", bus.busy, bus.done, bus.rec_level);
    end
  endtask

  task automatic test_empty();
    int e0, v0;
    e0 = n_end;
    v0 = n_valid;
    do_start();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL empty_done got=%b exp=1", bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle got=%b%b exp=00", bus.done, bus.busy);
    end
    checks++;
    if (n_valid != v0 || n_end != e0) begin
      errors++;
      $display("FAIL empty_quiet got=%0d/%0d exp=0/0", n_valid - v0, n_end - e0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    for (int i = 0; i < 16; i++) do_write(300);
    do_write(999);
    checks++;
    if (bus.wr_full !== 1'b1 || bus.overflow !== 1'b1 || bus.rec_level !== 7'd16) begin
      errors++;
      $display("FAIL ovf_state got=%b%b/%0d exp=11/16", bus.wr_full, bus.overflow, bus.rec_level);
    end
    do_start();
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
    end
    wait_done(400, 1, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_batch got=%b/%0d exp=1/0", ok, exp_q.size());
      exp_q.delete();
    end
    do_write(1000);
    do_start();
    wait_done(100, 1, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clamp_batch got=%b/%0d exp=1/0", ok, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_write(7);
    do_write(8);
    do_start();
    bus.wr_en = 1'b1;
    bus.wr_count = CNT_W'(42);
    mdl.push_back(42);
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.rec_level !== 7'd2) begin
      errors++;
      $display("FAIL pushpop_level got=%0d exp=2", bus.rec_level);
    end
    wait_done(200, 1, ok);
    checks++;
    if (!ok || bus.rec_level !== 7'd1) begin
      errors++;
      $display("FAIL b2b_first got=%b/%0d exp=1/1", ok, bus.rec_level);
    end
    do_start();
    wait_done(100, 1, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_second got=%b/%0d exp=1/0", ok, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int e0, b0;
    do_write(11);
    do_write(22);
    do_write(33);
    e0 = n_end;
    b0 = n_bytes;
    do_start();
    for (int c = 0; c < 40; c++) begin
      @(posedge txclk);
      #1;
      bus.data_accepted = 1'b1;
      @(negedge txclk);
      if (n_bytes - b0 >= 9) break;
    end
    @(posedge txclk);
    #1;
    reset_n = 1'b0;
    bus.data_accepted = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.data_out_valid, bus.data_end, bus.send_post} !== 4'b0
        || bus.rec_level !== 7'd0 || bus.data_out !== 8'h00) begin
      errors++;
      $display("FAIL midrst_out got=%b%b%b%b/%0d exp=0000/0", bus.busy,
        bus.data_out_valid, bus.data_end, bus.send_post, bus.rec_level);
    end
    exp_q.delete();
    mdl.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (n_end != e0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_noend got=%0d/%b exp=0/0", n_end - e0, bus.busy);
    end
    do_write(44);
    do_start();
    wait_done(100, 1, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_restart got=%b/%0d exp=1/0", ok, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_count = '0;
    bus.start = 1'b0;
    bus.data_accepted = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_basic(1);
    test_basic(3);
    test_empty();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
